// File: rtl/caliptra_fpga_apb_initiator.sv
// Hardware APB initiator: accepts one register-side request, runs one APB
// SETUP/ACCESS transfer on the Caliptra responder port, and returns one response.
module caliptra_fpga_apb_initiator #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int USER_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [2:0]        req_pprot,
  input  logic [USER_W-1:0] req_pauser,

  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_slverr,
  output logic              rsp_timeout,
  output logic [15:0]       wait_cycles,

  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  output logic [2:0]        pprot,
  output logic [USER_W-1:0] pauser,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  state_e              r_state;
  state_e              w_next_state;

  logic                r_write;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [2:0]          r_pprot;
  logic [USER_W-1:0]   r_pauser;

  logic [15:0]         r_wait_cnt;
  logic [DATA_W-1:0]   r_rsp_rdata;
  logic                r_rsp_slverr;
  logic                r_rsp_timeout;
  logic [15:0]         r_wait_cycles;

  logic                w_accept;
  logic                w_in_access;
  logic                w_timeout_hit;

  assign w_accept    = (r_state == ST_IDLE) && req_valid;
  assign w_in_access = (r_state == ST_ACCESS);

  // Counter is 16 bits and saturates, so a limit above 16'hFFFF never fires.
  assign w_timeout_hit = (TIMEOUT_CYCLES != 0) && (int'(r_wait_cnt) == TIMEOUT_CYCLES);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:   if (req_valid)             w_next_state = ST_SETUP;
      ST_SETUP:                             w_next_state = ST_ACCESS;
      ST_ACCESS: if (pready || w_timeout_hit) w_next_state = ST_RESP;
      ST_RESP:   if (rsp_ready)             w_next_state = ST_IDLE;
      default:                              w_next_state = ST_IDLE;
    endcase
  end

  // NOTE: every output gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    req_ready = 1'b0;
    psel      = 1'b0;
    penable   = 1'b0;
    rsp_valid = 1'b0;
    case (r_state)
      ST_IDLE:   req_ready = 1'b1;
      ST_SETUP:  psel      = 1'b1;
      ST_ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
      end
      ST_RESP:   rsp_valid = 1'b1;
      default:   ;
    endcase
  end

  // Request latch; APB address/data/attributes are driven straight from it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_write  <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_pprot  <= '0;
      r_pauser <= '0;
    end else if (w_accept) begin
      r_write  <= req_write;
      r_addr   <= req_addr;
      r_wdata  <= req_wdata;
      r_pprot  <= req_pprot;
      r_pauser <= req_pauser;
    end
  end

  // ACCESS-cycle counter: 1 in the first ACCESS cycle, saturating.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait_cnt <= '0;
    end else if (r_state == ST_SETUP) begin
      r_wait_cnt <= 16'd1;
    end else if (w_in_access && (r_wait_cnt != 16'hFFFF)) begin
      r_wait_cnt <= r_wait_cnt + 16'd1;
    end
  end

  // Response capture; pready wins over a timeout landing on the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_rdata   <= '0;
      r_rsp_slverr  <= 1'b0;
      r_rsp_timeout <= 1'b0;
      r_wait_cycles <= '0;
    end else if (w_in_access) begin
      if (pready) begin
        r_rsp_rdata   <= r_write ? '0 : prdata;
        r_rsp_slverr  <= pslverr;
        r_rsp_timeout <= 1'b0;
        r_wait_cycles <= r_wait_cnt;
      end else if (w_timeout_hit) begin
        r_rsp_rdata   <= '0;
        r_rsp_slverr  <= 1'b1;
        r_rsp_timeout <= 1'b1;
        r_wait_cycles <= r_wait_cnt;
      end
    end
  end

  assign pwrite      = r_write;
  assign paddr       = r_addr;
  assign pwdata      = r_wdata;
  assign pprot       = r_pprot;
  assign pauser      = r_pauser;

  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_slverr  = r_rsp_slverr;
  assign rsp_timeout = r_rsp_timeout;
  assign wait_cycles = r_wait_cycles;

endmodule

// File: tb/tb_caliptra_fpga_apb_initiator.sv
// Scoreboard bench for caliptra_fpga_apb_initiator: random requests, an APB
// responder model with planned wait states, and a decoupled response monitor.
module tb_caliptra_fpga_apb_initiator;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int USER_W = 32;
  localparam int TMO    = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid, req_ready, req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [2:0]        req_pprot;
  logic [USER_W-1:0] req_pauser;
  logic              rsp_valid, rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_slverr, rsp_timeout;
  logic [15:0]       wait_cycles;
  logic              psel, penable, pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [2:0]        pprot;
  logic [USER_W-1:0] pauser;
  logic [DATA_W-1:0] prdata;
  logic              pready, pslverr;

  always #5 clk = ~clk;

  caliptra_fpga_apb_initiator #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .USER_W(USER_W), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_pprot(req_pprot),
    .req_pauser(req_pauser),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_slverr(rsp_slverr), .rsp_timeout(rsp_timeout), .wait_cycles(wait_cycles),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pprot(pprot), .pauser(pauser),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  // One planned transfer: the request plus how the responder will answer it.
  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  pprot;
    logic [31:0] pauser;
    logic [7:0]  wait_n;   // ACCESS cycle on which pready rises
    logic [31:0] rdata;
    logic        slverr;
  } txn_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        slverr;
    logic        timeout;
    logic [15:0] wait_cycles;
    logic [15:0] latency;
    logic [31:0] accept_cyc;
  } exp_t;

  txn_t plan_q[$];
  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  int   hold_mode   = 0;  // 0 random rsp_ready, 1 held low, 2 held high
  int   hs_cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    vectors++;
    if (act !== exp_v) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
  endtask

  // Reference model: a transfer completes on its planned wait cycle unless
  // that lies beyond the timeout, in which case it is aborted at the limit.
  // Latency counts edges from accept to rsp_valid: one SETUP edge plus one
  // per ACCESS cycle.
  function automatic exp_t model(input txn_t t, input int accept_cyc);
    exp_t e;
    int   n;
    n = (int'(t.wait_n) <= TMO) ? int'(t.wait_n) : TMO;
    if (int'(t.wait_n) <= TMO) begin
      e.rdata   = t.write ? 32'h0 : t.rdata;
      e.slverr  = t.slverr;
      e.timeout = 1'b0;
    end else begin
      e.rdata   = 32'h0;
      e.slverr  = 1'b1;
      e.timeout = 1'b1;
    end
    e.wait_cycles = 16'(n);
    e.latency     = 16'(1 + n);
    e.accept_cyc  = 32'(accept_cyc);
    return e;
  endfunction

  function automatic txn_t mk(input logic w, input logic [31:0] a, input logic [31:0] d,
                              input int wn, input logic [31:0] rd, input logic se);
    txn_t t;
    t.write  = w;
    t.addr   = a;
    t.wdata  = d;
    t.pprot  = 3'($urandom);
    t.pauser = $urandom;
    t.wait_n = 8'(wn);
    t.rdata  = rd;
    t.slverr = se;
    return t;
  endfunction

  function automatic txn_t rand_txn();
    return mk(1'($urandom), $urandom, $urandom, int'($urandom_range(1, 11)),
              $urandom, ($urandom_range(0, 3) == 0));
  endfunction

  task automatic drive_req(input txn_t t);
    req_write  = t.write;
    req_addr   = t.addr;
    req_wdata  = t.wdata;
    req_pprot  = t.pprot;
    req_pauser = t.pauser;
  endtask

  // Hold a request until req_ready; record plan and expected response.
  task automatic send(input txn_t t, input bit expect_rsp);
    int guard;
    guard = 0;
    @(negedge clk);
    req_valid = 1'b1;
    drive_req(t);
    while (!req_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      fail("req_accept");
      req_valid = 1'b0;
      return;
    end
    plan_q.push_back(t);
    if (expect_rsp) exp_q.push_back(model(t, cyc + 1));
    @(negedge clk);
    req_valid = 1'b0;
    drive_req(rand_txn());
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || rsp_valid) && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 500) fail("drain");
  endtask

  // APB responder: pready only on the planned ACCESS cycle; noise elsewhere.
  txn_t cur;
  int   acc_cnt = 0;
  always @(negedge clk) begin
    if (psel && penable) begin
      if (acc_cnt == 0) begin
        if (plan_q.size() != 0) cur = plan_q.pop_front();
        else fail("plan_underflow");
      end
      acc_cnt++;
      check("access_ctl",  {28'h0, pwrite, pprot, paddr}, {28'h0, cur.write, cur.pprot, cur.addr});
      check("access_data", {pwdata, pauser}, {cur.wdata, cur.pauser});
      if (acc_cnt == int'(cur.wait_n)) begin
        pready  = 1'b1;
        prdata  = cur.rdata;
        pslverr = cur.slverr;
      end else begin
        pready  = 1'b0;
        prdata  = $urandom;
        pslverr = 1'($urandom);
      end
    end else begin
      if (psel && !penable && plan_q.size() != 0)
        check("setup_ctl", {28'h0, pwrite, pprot, paddr},
              {28'h0, plan_q[0].write, plan_q[0].pprot, plan_q[0].addr});
      acc_cnt = 0;
      pready  = 1'($urandom);
      prdata  = $urandom;
      pslverr = 1'($urandom);
    end
  end

  // Response monitor: pops on rsp_valid rising, checks stability while held.
  exp_t cur_exp;
  bit   seen = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      seen      = 1'b0;
      rsp_ready = 1'b0;
    end else begin
      if (rsp_valid) begin
        check("rsp_req_ready", {63'h0, req_ready}, 64'h0);
        check("rsp_psel", {62'h0, psel, penable}, 64'h0);
        if (!seen) begin
          seen = 1'b1;
          if (exp_q.size() == 0) fail("unexpected_rsp");
          else begin
            cur_exp = exp_q.pop_front();
            check("latency", 64'(cyc - int'(cur_exp.accept_cyc)), 64'(cur_exp.latency));
          end
        end
        check("rsp_rdata", 64'(rsp_rdata), 64'(cur_exp.rdata));
        check("rsp_flags", {62'h0, rsp_slverr, rsp_timeout}, {62'h0, cur_exp.slverr, cur_exp.timeout});
        check("wait_cycles", 64'(wait_cycles), 64'(cur_exp.wait_cycles));
      end
      case (hold_mode)
        0:       rsp_ready = ($urandom_range(0, 3) != 0);
        1:       rsp_ready = 1'b0;
        default: rsp_ready = 1'b1;
      endcase
      if (rsp_valid && rsp_ready) begin
        seen   = 1'b0;
        hs_cyc = cyc + 1;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    txn_t t;
    int   guard;
    rst = 1'b1;
    req_valid = 1'b0;
    drive_req(rand_txn());
    repeat (3) @(negedge clk);

    check("reset_req_ready", {63'h0, req_ready}, 64'h1);
    check("reset_apb_ctl", {61'h0, psel, penable, pwrite}, 64'h0);
    check("reset_paddr", 64'(paddr), 64'h0);
    check("reset_pwdata", {pwdata, pauser}, 64'h0);
    check("reset_rsp_valid", {63'h0, rsp_valid}, 64'h0);
    check("reset_rsp", {30'h0, rsp_slverr, rsp_timeout, rsp_rdata}, 64'h0);
    check("reset_wait_cycles", 64'(wait_cycles), 64'h0);
    rst = 1'b0;

    // Directed cases.
    send(mk(1'b1, 32'h0003_0030, 32'hDEAD_BEEF, 1, 32'h5555_AAAA, 1'b0), 1'b1);
    send(mk(1'b0, 32'h0003_0000, 32'h0,         5, 32'h1234_5678, 1'b0), 1'b1);
    send(mk(1'b0, 32'h0003_0004, 32'h0,         3, 32'hCAFE_F00D, 1'b1), 1'b1);
    send(mk(1'b0, 32'h0003_0008, 32'h0,         9, 32'hFFFF_FFFF, 1'b0), 1'b1);
    send(mk(1'b0, 32'h0003_000C, 32'h0,         8, 32'hA5A5_0008, 1'b0), 1'b1);
    send(mk(1'b1, 32'h0003_0011, 32'h0BAD_0001, 2, 32'h7777_7777, 1'b1), 1'b1);
    drain();

    for (int i = 0; i < 40; i++) send(rand_txn(), 1'b1);
    drain();

    // Backpressure: response held 10 cycles while a new request waits.
    hold_mode = 1;
    send(rand_txn(), 1'b1);
    guard = 0;
    while (!rsp_valid && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!rsp_valid) fail("bp_rsp_valid");
    t = rand_txn();
    req_valid = 1'b1;
    drive_req(t);
    repeat (10) begin
      check("bp_req_ready", {63'h0, req_ready}, 64'h0);
      check("bp_no_setup", {63'h0, psel}, 64'h0);
      @(negedge clk);
    end
    hold_mode = 2;
    guard = 0;
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) fail("bp_accept");
    else begin
      plan_q.push_back(t);
      exp_q.push_back(model(t, cyc + 1));
      check("b2b_accept", 64'(cyc + 1), 64'(hs_cyc + 1));
    end
    @(negedge clk);
    req_valid = 1'b0;
    drain();
    hold_mode = 0;

    // Reset during ACCESS aborts the transfer with no response.
    send(mk(1'b0, $urandom, $urandom, 50, $urandom, 1'b0), 1'b0);
    guard = 0;
    while (!(psel && penable) && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!(psel && penable)) fail("reach_access");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_access_apb", {62'h0, psel, penable}, 64'h0);
    check("rst_access_rsp_valid", {63'h0, rsp_valid}, 64'h0);
    check("rst_access_req_ready", {63'h0, req_ready}, 64'h1);
    rst = 1'b0;

    send(rand_txn(), 1'b1);
    drain();
    check("scoreboard_empty", 64'(exp_q.size()), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
